// File: rtl/obstacle_controller.sv
// rtl/obstacle_controller.sv - falling-obstacle FSM with LFSR spawn column, collision and score
// Optional feature macro: OBST_SPEEDUP_EN (fall speed grows with score, capped at 7 px/tick)
module obstacle_controller #(
   parameter int         OBST_W      = 16,
   parameter int         OBST_H      = 32,
   parameter int         ROAD_MIN_X  = 64,
   parameter int         Y_MAX       = 480,
   parameter int         SPEED       = 2,
   parameter int         SPAWN_DELAY = 30,
   parameter logic [2:0] OBST_COLOR  = 3'b001
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       restart,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       on_player,
   output logic [7:0] obst_x,
   output logic [9:0] obst_y,
   output logic       obst_active,
   output logic       on_obst,
   output logic [2:0] rgb_obst,
   output logic       crash,
   output logic [7:0] score
);

   localparam int               CNT_W    = $clog2(SPAWN_DELAY) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_DELAY - 1);
   localparam logic [10:0]      Y_LIMIT  = 11'(Y_MAX);

   typedef enum logic [1:0] {WAIT, SPAWN, MOVE, CRASH} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] spawn_cnt, spawn_cnt_nx;
   logic [7:0]       obst_x_nx;
   logic [9:0]       obst_y_nx;
   logic [7:0]       score_nx;
   logic [15:0]      lfsr;
   logic             lfsr_fb;
   logic [10:0]      speed;
   logic [10:0]      y_next;
   logic [11:0]      x_lo, x_hi, y_lo, y_hi, px, py;
   logic             hit;

`ifdef OBST_SPEEDUP_EN
   logic [5:0] speed_sum;
   assign speed_sum = 6'(SPEED) + {1'b0, score[7:3]};
   assign speed     = (speed_sum > 6'd7) ? 11'd7 : 11'(speed_sum);
`else
   assign speed = 11'(SPEED);
`endif

   assign y_next = {1'b0, obst_y} + speed;

   // 12-bit bounds so obst_x+OBST_W and obst_y+OBST_H can never wrap
   assign x_lo = {4'b0, obst_x};
   assign x_hi = x_lo + 12'(OBST_W);
   assign y_lo = {2'b0, obst_y};
   assign y_hi = y_lo + 12'(OBST_H);
   assign px   = {2'b0, pixel_x};
   assign py   = {2'b0, pixel_y};

   assign obst_active = (state == MOVE) || (state == CRASH);
   assign crash       = (state == CRASH);
   assign on_obst     = obst_active && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
   assign rgb_obst    = on_obst ? OBST_COLOR : 3'b000;
   assign hit         = on_obst && on_player;

   // taps 16,14,13,11 in right-shifting Fibonacci form
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= WAIT;
         spawn_cnt <= '0;
         obst_x    <= '0;
         obst_y    <= '0;
         score     <= '0;
         lfsr      <= 16'hACE1;
      end else begin
         state     <= state_nx;
         spawn_cnt <= spawn_cnt_nx;
         obst_x    <= obst_x_nx;
         obst_y    <= obst_y_nx;
         score     <= score_nx;
         lfsr      <= {lfsr_fb, lfsr[15:1]};
      end
   end

   always_comb begin
      state_nx     = state;
      spawn_cnt_nx = spawn_cnt;
      obst_x_nx    = obst_x;
      obst_y_nx    = obst_y;
      score_nx     = score;
      case (state)
         WAIT: begin
            if (tick) begin
               if (spawn_cnt == CNT_LAST) begin
                  spawn_cnt_nx = '0;
                  state_nx     = SPAWN;
               end else begin
                  spawn_cnt_nx = spawn_cnt + 1'b1;
               end
            end
         end
         SPAWN: begin
            obst_x_nx = 8'(ROAD_MIN_X) + {1'b0, lfsr[6:0]};
            obst_y_nx = '0;
            state_nx  = MOVE;
         end
         MOVE: begin
            // a collision wins over reaching the bottom, so no score for that obstacle
            if (hit) begin
               state_nx = CRASH;
            end else if (tick) begin
               if (y_next >= Y_LIMIT) begin
                  state_nx = WAIT;
                  if (score != 8'hFF) score_nx = score + 8'd1;
               end else begin
                  obst_y_nx = y_next[9:0];
               end
            end
         end
         CRASH: begin
            if (restart) begin
               state_nx     = WAIT;
               score_nx     = '0;
               spawn_cnt_nx = '0;
            end
         end
         default: state_nx = WAIT;
      endcase
   end

endmodule

// File: tb/tb_obstacle_controller.sv
// tb/tb_obstacle_controller.sv - scoreboard bench for obstacle_controller
`timescale 1ns/1ps
module tb_obstacle_controller;

   localparam int         OBST_W      = 16;
   localparam int         OBST_H      = 32;
   localparam int         ROAD_MIN_X  = 64;
   localparam int         Y_MAX       = 480;
   localparam int         SPEED       = 2;
   localparam int         SPAWN_DELAY = 30;
   localparam logic [2:0] OBST_COLOR  = 3'b001;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       restart = 1'b0;
   logic       on_player = 1'b0;
   logic [9:0] pixel_x = 10'h3FF;
   logic [9:0] pixel_y = 10'h3FF;
   logic [7:0] obst_x;
   logic [9:0] obst_y;
   logic       obst_active, on_obst, crash;
   logic [2:0] rgb_obst;
   logic [7:0] score;

   logic       tick2 = 1'b0;
   logic       restart2 = 1'b0;
   logic       on_player2 = 1'b0;
   logic [9:0] pixel_x2 = 10'h3FF;
   logic [9:0] pixel_y2 = 10'h3FF;
   logic [7:0] obst_x2;
   logic [9:0] obst_y2;
   logic       obst_active2, on_obst2, crash2;
   logic [2:0] rgb_obst2;
   logic [7:0] score2;

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] e;
   logic [15:0] m_lfsr, m_prev;

   obstacle_controller #(
      .OBST_W(OBST_W), .OBST_H(OBST_H), .ROAD_MIN_X(ROAD_MIN_X), .Y_MAX(Y_MAX),
      .SPEED(SPEED), .SPAWN_DELAY(SPAWN_DELAY), .OBST_COLOR(OBST_COLOR)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .restart(restart),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .on_player(on_player),
      .obst_x(obst_x), .obst_y(obst_y), .obst_active(obst_active), .on_obst(on_obst),
      .rgb_obst(rgb_obst), .crash(crash), .score(score)
   );

   // short-lifetime instance so saturation is reachable in few cycles
   obstacle_controller #(
      .OBST_W(OBST_W), .OBST_H(OBST_H), .ROAD_MIN_X(ROAD_MIN_X), .Y_MAX(2),
      .SPEED(SPEED), .SPAWN_DELAY(1), .OBST_COLOR(OBST_COLOR)
   ) dut_sat (
      .clk(clk), .reset(reset), .tick(tick2), .restart(restart2),
      .pixel_x(pixel_x2), .pixel_y(pixel_y2), .on_player(on_player2),
      .obst_x(obst_x2), .obst_y(obst_y2), .obst_active(obst_active2), .on_obst(on_obst2),
      .rgb_obst(rgb_obst2), .crash(crash2), .score(score2)
   );

   always #5 clk = ~clk;

   // reference LFSR; m_prev holds the value that was current before the latest edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_lfsr <= 16'hACE1;
         m_prev <= 16'hACE1;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      end
   end

   task automatic do_tick();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
   endtask

   task automatic do_tick2();
      @(negedge clk); tick2 = 1'b1;
      @(negedge clk); tick2 = 1'b0;
   endtask

   task automatic pulse_restart();
      @(negedge clk); restart = 1'b1;
      @(negedge clk); restart = 1'b0;
   endtask

   task automatic spawn();
      repeat (SPAWN_DELAY) do_tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      pixel_x = 10'd0; pixel_y = 10'd0;
      repeat (3) @(negedge clk);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if ({obst_x, obst_y, score, obst_active, on_obst, crash, rgb_obst} !== e)
         $display("FAIL reset_outputs: got %h expected %h", {obst_x, obst_y, score, obst_active, on_obst, crash, rgb_obst}, e);
      else pass_cnt++;
      reset = 1'b1;
      pixel_x = 10'h3FF; pixel_y = 10'h3FF;
      @(negedge clk);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'({obst_active, crash}) !== e) $display("FAIL reset_release_idle: got %0d expected %0d", {obst_active, crash}, e);
      else pass_cnt++;
   endtask

   task automatic test_spawn();
      repeat (SPAWN_DELAY - 1) do_tick();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_active) !== e) $display("FAIL spawn_too_early: got %0d expected %0d", obst_active, e);
      else pass_cnt++;
      do_tick();
      @(negedge clk);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'(ROAD_MIN_X) + 32'(m_prev[6:0]));
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_active) !== e) $display("FAIL spawn_active: got %0d expected %0d", obst_active, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_y) !== e) $display("FAIL spawn_y: got %0d expected %0d", obst_y, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_x) !== e) $display("FAIL spawn_x_lfsr: got %0d expected %0d", obst_x, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_x >= 8'd64 && obst_x <= 8'd191) !== e) $display("FAIL spawn_x_range: got %0d expected in [64,191]", obst_x);
      else pass_cnt++;
   endtask

   task automatic test_on_obst();
      logic [9:0] xs[4];
      logic [9:0] ys[4];
      logic [31:0] want[4];
      xs[0] = 10'(obst_x) + 10'(OBST_W - 1); ys[0] = 10'(OBST_H - 1); want[0] = 32'd1;
      xs[1] = 10'(obst_x) + 10'(OBST_W);     ys[1] = 10'd0;           want[1] = 32'd0;
      xs[2] = 10'(obst_x) - 10'd1;           ys[2] = 10'd0;           want[2] = 32'd0;
      xs[3] = 10'(obst_x);                   ys[3] = 10'(OBST_H);     want[3] = 32'd0;
      for (int i = 0; i < 4; i++) begin
         pixel_x = xs[i]; pixel_y = ys[i];
         exp_q.push_back({29'd0, want[i][0] ? OBST_COLOR : 3'b000});
         exp_q.push_back(want[i]);
         #1;
         e = exp_q.pop_front(); chk_cnt++;
         if (32'(rgb_obst) !== e) $display("FAIL on_obst_rgb[%0d]: got %0d expected %0d", i, rgb_obst, e);
         else pass_cnt++;
         e = exp_q.pop_front(); chk_cnt++;
         if (32'(on_obst) !== e) $display("FAIL on_obst_edge[%0d]: got %0d expected %0d", i, on_obst, e);
         else pass_cnt++;
      end
      pixel_x = 10'h3FF; pixel_y = 10'h3FF;
   endtask

   task automatic test_move();
      repeat (10) do_tick();
      exp_q.push_back(32'd20);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_y) !== e) $display("FAIL move_y10: got %0d expected %0d", obst_y, e);
      else pass_cnt++;
      pulse_restart();
      exp_q.push_back({31'd0, 1'b1});
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_active && obst_y == 10'd20) !== e) $display("FAIL restart_in_move: got y=%0d active=%0d expected y=20 active=1", obst_y, obst_active);
      else pass_cnt++;
      repeat (229) do_tick();
      exp_q.push_back(32'd478);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_y) !== e) $display("FAIL move_y239: got %0d expected %0d", obst_y, e);
      else pass_cnt++;
      do_tick();
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_active) !== e) $display("FAIL move_bottom_active: got %0d expected %0d", obst_active, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(score) !== e) $display("FAIL move_bottom_score: got %0d expected %0d", score, e);
      else pass_cnt++;
   endtask

   task automatic test_crash();
      spawn();
      repeat (5) do_tick();
      pixel_x = 10'(obst_x); pixel_y = obst_y + 10'd5; on_player = 1'b1;
      @(negedge clk);
      on_player = 1'b0; pixel_x = 10'h3FF; pixel_y = 10'h3FF;
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(crash) !== e) $display("FAIL crash_set: got %0d expected %0d", crash, e);
      else pass_cnt++;
      repeat (3) do_tick();
      exp_q.push_back(32'd10);
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_y) !== e) $display("FAIL crash_y_frozen: got %0d expected %0d", obst_y, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(score) !== e) $display("FAIL crash_score_frozen: got %0d expected %0d", score, e);
      else pass_cnt++;
      pulse_restart();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'({crash, score, obst_active}) !== e) $display("FAIL crash_restart: got crash=%0d score=%0d active=%0d expected all 0", crash, score, obst_active);
      else pass_cnt++;
   endtask

   task automatic test_crash_at_bottom();
      spawn();
      repeat (239) do_tick();
      @(negedge clk);
      pixel_x = 10'(obst_x); pixel_y = obst_y + 10'd5; on_player = 1'b1; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; on_player = 1'b0; pixel_x = 10'h3FF; pixel_y = 10'h3FF;
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd478);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(crash) !== e) $display("FAIL bottom_crash: got %0d expected %0d", crash, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(score) !== e) $display("FAIL bottom_score: got %0d expected %0d", score, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_y) !== e) $display("FAIL bottom_y: got %0d expected %0d", obst_y, e);
      else pass_cnt++;
      pulse_restart();
   endtask

`ifdef OBST_SPEEDUP_EN
   task automatic test_speedup();
      int budget;
      for (int i = 0; i < 16; i++) begin
         spawn();
         budget = 0;
         while (obst_active && budget < 400) begin
            do_tick();
            budget++;
         end
      end
      exp_q.push_back(32'd16);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(score) !== e) $display("FAIL speedup_score: got %0d expected %0d", score, e);
      else pass_cnt++;
      spawn();
      do_tick();
      exp_q.push_back(32'd4);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_y) !== e) $display("FAIL speedup_step: got %0d expected %0d", obst_y, e);
      else pass_cnt++;
      budget = 0;
      while (obst_active && budget < 400) begin
         do_tick();
         budget++;
      end
   endtask
`endif

   task automatic test_reset_mid_move();
      spawn();
      repeat (5) do_tick();
      pixel_x = 10'(obst_x); pixel_y = obst_y;
      #1;
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(on_obst) !== e) $display("FAIL midreset_pre_on_obst: got %0d expected %0d", on_obst, e);
      else pass_cnt++;
      reset = 1'b0;
      #1;
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if ({obst_x, obst_y, score, obst_active, on_obst, crash, rgb_obst} !== e)
         $display("FAIL midreset_outputs: got %h expected %h", {obst_x, obst_y, score, obst_active, on_obst, crash, rgb_obst}, e);
      else pass_cnt++;
      pixel_x = 10'h3FF; pixel_y = 10'h3FF;
      @(negedge clk);
      reset = 1'b1;
      repeat (SPAWN_DELAY - 1) do_tick();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_active) !== e) $display("FAIL midreset_spawn_early: got %0d expected %0d", obst_active, e);
      else pass_cnt++;
      do_tick();
      @(negedge clk);
      exp_q.push_back(32'(ROAD_MIN_X) + 32'(m_prev[6:0]));
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_x) !== e) $display("FAIL midreset_lfsr_x: got %0d expected %0d", obst_x, e);
      else pass_cnt++;
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 255; i++) begin
         do_tick2();
         do_tick2();
      end
      exp_q.push_back(32'd255);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(score2) !== e) $display("FAIL sat_255: got %0d expected %0d", score2, e);
      else pass_cnt++;
      do_tick2();
      do_tick2();
      exp_q.push_back(32'd255);
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(score2) !== e) $display("FAIL sat_256: got %0d expected %0d", score2, e);
      else pass_cnt++;
      e = exp_q.pop_front(); chk_cnt++;
      if (32'(obst_active2) !== e) $display("FAIL sat_back_to_wait: got %0d expected %0d", obst_active2, e);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_spawn();
      test_on_obst();
      test_move();
      test_crash();
      test_crash_at_bottom();
`ifdef OBST_SPEEDUP_EN
      test_speedup();
`endif
      test_reset_mid_move();
      test_saturate();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/obstacle_controller.md
OBSTACLE_CONTROLLER -- requirements
Module: obstacle_controller

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning):
  OBST_W  16  obstacle width in pixels
  OBST_H  32  obstacle height in pixels
  ROAD_MIN_X  64  leftmost spawn column; ROAD_MIN_X+127+OBST_W SHALL be <= 255
  Y_MAX  480  bottom row limit
  SPEED  2  pixels moved per tick
  SPAWN_DELAY  30  ticks between despawn and next spawn
  OBST_COLOR  3'b001  rgb of obstacle pixels, bit0=r, bit1=g, bit2=b
REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
  clk  in  1  system clock, the only clock
  reset  in  1  asynchronous, active-low reset
  tick  in  1  one-clk-wide frame update pulse from the update-signal divider
  restart  in  1  one-clk pulse; leaves CRASH
  pixel_x  in  10  current VGA column
  pixel_y  in  10  current VGA row
  on_player  in  1  player car graphic covers the current pixel
  obst_x  out  8  obstacle left column
  obst_y  out  10  obstacle top row
  obst_active  out  1  obstacle is on screen
  on_obst  out  1  obstacle covers the current pixel
  rgb_obst  out  3  obstacle colour
  crash  out  1  high while in CRASH
  score  out  8  obstacles survived, saturating

Function
REQ-003 The FSM SHALL have states WAIT, SPAWN, MOVE, CRASH.
REQ-004 WAIT: obst_active=0; spawn_cnt SHALL increment on each tick; when tick arrives with spawn_cnt==SPAWN_DELAY-1, spawn_cnt SHALL clear and the FSM SHALL enter SPAWN.
REQ-005 SPAWN: lasts exactly one clk; obst_x <= ROAD_MIN_X + lfsr[6:0]; obst_y <= 0; next state MOVE.
REQ-006 MOVE: obst_active=1; on tick, obst_y SHALL advance by the current speed (11-bit compare, no wrap); if obst_y+speed >= Y_MAX, the FSM SHALL go to WAIT and score SHALL increment, saturating at 255.
REQ-007 on_obst SHALL be combinational: obst_active && zero-extended obst_x <= pixel_x < obst_x+OBST_W && obst_y <= pixel_y < obst_y+OBST_H, using widths that cannot overflow.
REQ-008 rgb_obst SHALL be OBST_COLOR whenever on_obst=1, else 0.
REQ-009 In MOVE, a clk edge with on_obst && on_player SHALL enter CRASH on the next edge; crash SHALL be 1 from that edge.
REQ-010 CRASH: obst_x, obst_y and score SHALL be frozen and obst_active=1; tick is ignored.
REQ-011 restart in CRASH SHALL go to WAIT, clear score and spawn_cnt, and drop crash the next cycle; restart in other states SHALL be ignored.
REQ-012 Priority on the same edge: restart > collision > bottom-reached > tick movement; on collision plus bottom, the score SHALL NOT increment.
REQ-013 The LFSR SHALL be 16-bit Fibonacci (taps 16,14,13,11), stepping every clk in all states; it SHALL never reach zero.

Reset
REQ-014 While reset=0: state=WAIT, spawn_cnt=0, obst_x=0, obst_y=0, score=0, lfsr=16'hACE1; this forces obst_active=0, crash=0, on_obst=0, rgb_obst=0.
REQ-015 Reset asserted mid-MOVE or mid-CRASH SHALL take effect immediately; after release, the first spawn SHALL occur SPAWN_DELAY ticks later.

Configuration
REQ-016 With OBST_SPEEDUP_EN defined: speed = SPEED + score[7:3], capped at 7; speed is sampled in the cycle it is used.
REQ-017 Without OBST_SPEEDUP_EN: speed SHALL be constant SPEED, with no extra logic.

Verification
REQ-018 Reset release, 30 ticks -> SPAWN one clk later; obst_active=1, obst_y=0, obst_x in [64,191].
REQ-019 MOVE with SPEED=2 and no player overlap -> after 240 ticks, return to WAIT; score=1; obst_active=0.
REQ-020 Drive on_player=1 while pixel equals (obst_x, obst_y+5) -> crash=1 next clk; further ticks leave obst_y unchanged; restart pulse -> crash=0, score=0, state WAIT.
REQ-021 Collision coincident with the bottom-reaching tick -> CRASH; score unchanged.
REQ-022 Score preloaded by 255 survivals -> the 256th keeps score=255; with OBST_SPEEDUP_EN, score=16 -> step is 4 pixels/tick.
REQ-023 Assert reset mid-MOVE -> all outputs zero in the same cycle; the LFSR restarts at 16'hACE1.
